// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU and a secondary requester.
package ram_arb_pkg;

  localparam int unsigned CntW        = 4;
  localparam int unsigned AddrW       = 15;
  localparam int unsigned DataW       = 16;
  localparam int unsigned DefMaxWait  = 8;
  localparam int unsigned DefBurstLen = 4;

  typedef enum logic {
    StCpu = 1'b0,
    StSec = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_rd_tracker.sv
// Remembers which port was granted a read last cycle and raises that port's rvalid now.
module arb_rd_tracker #(
  parameter int unsigned NumPorts = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NumPorts-1:0] rd_gnt_i,
  output logic [NumPorts-1:0] rvalid_o
);

  logic [NumPorts-1:0] rd_tag_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_tag_q <= '0;
    end else begin
      rd_tag_q <= rd_gnt_i;
    end
  end

  assign rvalid_o = rd_tag_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (priority) and a bursting secondary port
// with a starvation limit; a refused CPU is held off through cpu_stall_o.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned MaxWait  = DefMaxWait,
  parameter int unsigned BurstLen = DefBurstLen
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [DataW-1:0] cpu_din_i,
  output logic [DataW-1:0] cpu_dout_o,
  output logic             cpu_rvalid_o,
  output logic             cpu_stall_o,
  input  logic             sec_req_i,
  input  logic             sec_we_i,
  input  logic [AddrW-1:0] sec_addr_i,
  input  logic [DataW-1:0] sec_din_i,
  output logic             sec_gnt_o,
  output logic [DataW-1:0] sec_dout_o,
  output logic             sec_rvalid_o,
  output logic             ram_wr_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [DataW-1:0] ram_din_o,
  input  logic [DataW-1:0] ram_dout_i
);

  localparam logic [CntW-1:0] MaxWaitC   = CntW'(MaxWait);
  localparam logic [CntW-1:0] BurstLastC = CntW'(BurstLen - 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            cpu_gnt, sec_gnt;
  logic [1:0]      rd_gnt, rvalid;

  // Zero-latency grant decode from the current state.
  always_comb begin
    cpu_gnt = 1'b0;
    sec_gnt = 1'b0;
    unique case (state_q)
      StCpu: begin
        if (cpu_req_i && !(sec_req_i && (wait_cnt_q == MaxWaitC))) begin
          cpu_gnt = 1'b1;
        end else if (sec_req_i) begin
          sec_gnt = 1'b1;
        end
      end
      StSec:   sec_gnt = sec_req_i;
      default: ;
    endcase
  end

  // burst_cnt counts secondary grants already taken in the current burst, so the burst
  // is closed on the grant that brings the total to BurstLen.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;

    if (sec_gnt || !sec_req_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StCpu: begin
        if (sec_gnt && (BurstLen > 1)) begin
          state_d     = StSec;
          burst_cnt_d = CntW'(1);
        end
      end
      StSec: begin
        if (!sec_req_i || (burst_cnt_q == BurstLastC)) begin
          state_d     = StCpu;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
        end
      end
      default: state_d = StCpu;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StCpu;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign rd_gnt = {sec_gnt && !sec_we_i, cpu_gnt && !cpu_we_i};

  arb_rd_tracker #(
    .NumPorts(2)
  ) u_rd_tracker (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .rd_gnt_i(rd_gnt),
    .rvalid_o(rvalid)
  );

  // Idle cycles leave the CPU address/data on the RAM bus; writes are blocked during reset.
  assign ram_addr_o = sec_gnt ? sec_addr_i : cpu_addr_i;
  assign ram_din_o  = sec_gnt ? sec_din_i : cpu_din_i;
  assign ram_wr_o   = reset_ni && ((cpu_gnt && cpu_we_i) || (sec_gnt && sec_we_i));

  assign cpu_stall_o  = cpu_req_i && !cpu_gnt;
  assign sec_gnt_o    = sec_gnt;
  assign cpu_rvalid_o = rvalid[0];
  assign sec_rvalid_o = rvalid[1];
  assign cpu_dout_o   = ram_dout_i;
  assign sec_dout_o   = ram_dout_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Vector-table bench for ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, sec_req, sec_we;
  logic [14:0] cpu_addr, sec_addr;
  logic [15:0] cpu_din, sec_din;
  logic [15:0] cpu_dout, sec_dout, ram_din, ram_dout;
  logic        cpu_rvalid, cpu_stall, sec_gnt, sec_rvalid, ram_wr;
  logic [14:0] ram_addr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem     [int];
  logic [15:0] ref_mem [int];
  logic [15:0] cpu_q[$];
  logic [15:0] sec_q[$];

  typedef struct {
    int          seg;
    logic        rn;
    logic        creq;
    logic        cwe;
    logic [14:0] ca;
    logic [15:0] cd;
    logic        sreq;
    logic        swe;
    logic [14:0] sa;
    logic [15:0] sd;
    logic        cg;
    logic        sg;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ram_arbiter #(
    .MaxWait (8),
    .BurstLen(4)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_din_i   (cpu_din),
    .cpu_dout_o  (cpu_dout),
    .cpu_rvalid_o(cpu_rvalid),
    .cpu_stall_o (cpu_stall),
    .sec_req_i   (sec_req),
    .sec_we_i    (sec_we),
    .sec_addr_i  (sec_addr),
    .sec_din_i   (sec_din),
    .sec_gnt_o   (sec_gnt),
    .sec_dout_o  (sec_dout),
    .sec_rvalid_o(sec_rvalid),
    .ram_wr_o    (ram_wr),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout)
  );

  // Unwritten RAM locations read back as an address-derived pattern.
  function automatic logic [15:0] pat(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : pat(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  function automatic vec_t mk(input int seg, input logic rn,
                              input logic creq, input logic cwe, input logic [14:0] ca,
                              input logic [15:0] cd, input logic sreq, input logic swe,
                              input logic [14:0] sa, input logic [15:0] sd,
                              input logic cg, input logic sg);
    vec_t v;
    v.seg = seg;  v.rn = rn;
    v.creq = creq; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.sreq = sreq; v.swe = swe; v.sa = sa; v.sd = sd;
    v.cg = cg;    v.sg = sg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic add_rst(input int seg);
    vecs.push_back(mk(seg, 0, 0, 0, 15'd0, 16'd0, 0, 0, 15'd0, 16'd0, 0, 0));
  endtask

  // One clock cycle: drive, check combinational outputs, clock the RAM, check read return.
  task automatic step(input vec_t v, input int idx);
    string       nm;
    logic        exp_wr, exp_crd, exp_srd, s_wr;
    logic [14:0] s_addr;
    logic [15:0] s_din, rd_data, exp_d;
    nm = $sformatf("seg%0d.v%0d", v.seg, idx);
    reset_n  = v.rn;
    cpu_req  = v.creq; cpu_we = v.cwe; cpu_addr = v.ca; cpu_din = v.cd;
    sec_req  = v.sreq; sec_we = v.swe; sec_addr = v.sa; sec_din = v.sd;
    #3;
    exp_wr  = v.rn && ((v.cg && v.cwe) || (v.sg && v.swe));
    exp_crd = v.rn && v.cg && !v.cwe;
    exp_srd = v.rn && v.sg && !v.swe;
    chk({nm, " cpu_stall"}, 32'(cpu_stall), 32'(v.creq && !v.cg));
    chk({nm, " sec_gnt"}, 32'(sec_gnt), 32'(v.sg));
    chk({nm, " ram_wr"}, 32'(ram_wr), 32'(exp_wr));
    chk({nm, " ram_addr"}, 32'(ram_addr), 32'(v.sg ? v.sa : v.ca));
    if (exp_wr) chk({nm, " ram_din"}, 32'(ram_din), 32'(v.sg ? v.sd : v.cd));
    if (exp_crd) cpu_q.push_back(ref_rd(v.ca));
    if (exp_srd) sec_q.push_back(ref_rd(v.sa));
    s_wr = ram_wr; s_addr = ram_addr; s_din = ram_din;
    rd_data = mem_rd(s_addr);
    @(posedge clk);
    ram_dout = rd_data;
    if (s_wr) mem[int'(s_addr)] = s_din;
    if (exp_wr) ref_mem[int'(v.sg ? v.sa : v.ca)] = v.sg ? v.sd : v.cd;
    #1;
    chk({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(exp_crd));
    chk({nm, " sec_rvalid"}, 32'(sec_rvalid), 32'(exp_srd));
    if (exp_crd) begin
      exp_d = cpu_q.pop_front();
      chk({nm, " cpu_dout"}, 32'(cpu_dout), 32'(exp_d));
    end
    if (exp_srd) begin
      exp_d = sec_q.pop_front();
      chk({nm, " sec_dout"}, 32'(sec_dout), 32'(exp_d));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    ram_dout = 16'd0;
    // 1: reset, CPU write 100 @100 then read it back.
    add_rst(1); add_rst(1);
    vecs.push_back(mk(1, 1, 1, 1, 15'd100, 16'd100, 0, 0, 15'd0, 16'd0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 15'd100, 16'd0, 0, 0, 15'd0, 16'd0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 15'd3, 16'd0, 0, 0, 15'd0, 16'd0, 0, 0));
    // 2: secondary-only reads; burst of 4, then regranted from the CPU state.
    add_rst(2);
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(2, 1, 0, 0, 15'd0, 16'd0, 1, 0, 15'h4000 + 15'(i), 16'd0, 0, 1));
    // 3: both requesting continuously; starvation limit forces a 4-cycle secondary burst.
    add_rst(3);
    for (int c = 0; c < 14; c++)
      vecs.push_back(mk(3, 1, 1, 0, 15'(c), 16'd0, 1, 0, 15'h4100 + 15'(c), 16'd0,
                        (c < 8) || (c >= 12), (c >= 8) && (c < 12)));
    // 4: sec_req drops mid-burst; CPU takes the RAM the cycle after; next burst is full length.
    add_rst(4);
    vecs.push_back(mk(4, 1, 0, 0, 15'h20, 16'd0, 1, 0, 15'h10, 16'd0, 0, 1));
    vecs.push_back(mk(4, 1, 1, 0, 15'h20, 16'd0, 1, 0, 15'h11, 16'd0, 0, 1));
    vecs.push_back(mk(4, 1, 1, 0, 15'h20, 16'd0, 0, 0, 15'h12, 16'd0, 0, 0));
    vecs.push_back(mk(4, 1, 1, 0, 15'h20, 16'd0, 0, 0, 15'h12, 16'd0, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4, 1, 0, 0, 15'h21, 16'd0, 1, 0, 15'h30 + 15'(i), 16'd0, 0, 1));
    vecs.push_back(mk(4, 1, 1, 0, 15'h22, 16'd0, 1, 0, 15'h34, 16'd0, 1, 0));
    // 5: reset right after a CPU read grant; write attempted during reset must not land.
    add_rst(5);
    vecs.push_back(mk(5, 1, 1, 0, 15'd7, 16'd0, 0, 0, 15'd0, 16'd0, 1, 0));
    vecs.push_back(mk(5, 0, 1, 0, 15'd7, 16'd0, 0, 0, 15'd0, 16'd0, 1, 0));
    vecs.push_back(mk(5, 0, 1, 1, 15'd7, 16'hDEAD, 0, 0, 15'd0, 16'd0, 1, 0));
    vecs.push_back(mk(5, 1, 1, 0, 15'd7, 16'd0, 0, 0, 15'd0, 16'd0, 1, 0));
    // 6: simultaneous writes to 100; CPU first (199), secondary lands later (5).
    add_rst(6);
    vecs.push_back(mk(6, 1, 1, 1, 15'd100, 16'd199, 1, 1, 15'd100, 16'd5, 1, 0));
    vecs.push_back(mk(6, 1, 1, 0, 15'd100, 16'd0, 1, 1, 15'd100, 16'd5, 1, 0));
    vecs.push_back(mk(6, 1, 0, 0, 15'd100, 16'd0, 1, 1, 15'd100, 16'd5, 0, 1));
    vecs.push_back(mk(6, 1, 0, 0, 15'd100, 16'd0, 0, 0, 15'd100, 16'd0, 0, 0));
    vecs.push_back(mk(6, 1, 1, 0, 15'd100, 16'd0, 0, 0, 15'd0, 16'd0, 1, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
